bcd_xs3_serial_codec: RTL
=========================

# bcd_xs3_serial_codec

Multi-digit, nibble-serial BCD/Excess-3 codec with valid/ready handshakes on both sides. It accepts a packed word of `DIGITS` codes and converts one digit per clock, least-significant digit first. The direction is selectable per transaction: encode (BCD→XS3) or decode (XS3→BCD). It is the sequential, parametrised successor to the single-digit combinational converter and sits between numeric-display and BCD-arithmetic datapaths.

## Interface
Parameters:
- `DIGITS`, default 4: number of 4-bit digits per word; legal range 1..16.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  4*DIGITS  packed digits; digit i occupies bits [4i+3:4i].
- `in_mode`  in  1  0 = encode BCD→XS3, 1 = decode XS3→BCD; sampled on the accept edge.
- `out_valid`  out  1  result word present.
- `out_ready`  in  1  downstream consumes the result.
- `out_data`  out  4*DIGITS  converted word, same packing as `in_data`.
- `out_err`  out  DIGITS  per-digit invalid-code flag; present only with `BCD_XS3_ERR_EN`.
- `out_any_err`  out  1  OR of `out_err`; present only with `BCD_XS3_ERR_EN`.
- `busy`  out  1  high in CONV or DONE.

## Operation
- The FSM has three states:
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `in_data` and `in_mode`, clear the digit index to 0, and go to CONV.
  - CONV: each cycle, convert digit[idx] and write it into the result register, then increment idx. On the edge that writes digit DIGITS-1, set `out_valid` and go to DONE.
  - DONE: hold `out_data` and `out_err` stable. On `out_valid && out_ready`, clear `out_valid` and go to IDLE.
- `in_ready` = (state==IDLE) && !rst. Input is never accepted in CONV or DONE.
- Encode: out = (d + 3) mod 16. A digit is invalid if d > 9.
- Decode: out = (d − 3) mod 16. A digit is invalid if d < 3 or d > 12.
- All arithmetic is 4-bit and wraps; there is no carry between digits.
- Invalid digits are still converted with wraparound; they are never saturated or zeroed.
- Reset values:
  - state IDLE, idx 0.
  - `out_valid` 0, `out_data` 0, `out_err` 0, `out_any_err` 0, `busy` 0.
  - `in_ready` 0 while `rst` is high, 1 in the first cycle after `rst` is released.
- Reset asserted during CONV or DONE aborts the transaction; the partial result is discarded and never presented.
- `in_mode` and `in_data` changing after the accept edge have no effect.
- When DIGITS=1, CONV lasts exactly one cycle.

## Timing
- Call the accept edge E. Digit i is written at edge E+1+i. `out_valid` rises at edge E+DIGITS.
- The latency from accept to `out_valid` is DIGITS cycles.
- If `out_ready` is already high, the result is consumed at edge E+DIGITS+1. The next accept is possible at edge E+DIGITS+2.
- Sustained throughput is one word per DIGITS+2 cycles.
- `out_data` and `out_err` change only on CONV edges. While `out_valid` is high with `out_ready` low, they are stable for any number of cycles.
- There is no combinational path from `in_*` to `out_*`, and none from `out_ready` to `in_ready`.

## Configuration
- Macro `BCD_XS3_ERR_EN`.
- When defined:
  - Per-digit validity checking is compiled in.
  - The `out_err[i]` register is written together with digit i.
  - `out_any_err` is registered and valid whenever `out_valid` is high.
- When undefined:
  - The `out_err` and `out_any_err` ports and their logic are absent.
  - `out_data` behaviour is identical (still mod-16 conversion).

## Structure
- Package `bcd_xs3_pkg` holds:
  - `xs3_mode_t` enum: ENCODE=0, DECODE=1.
  - `codec_state_t` enum: IDLE, CONV, DONE.
  - Constant `XS3_OFFSET` = 4'd3.
  - BCD maximum 4'd9; XS3 valid range 4'd3..4'd12.
- One sub-module, `xs3_digit`: a combinational single-digit converter with inputs `d[3:0]` and `mode`, and outputs `q[3:0]` and `err`. It is instantiated once and multiplexed by idx.

## Test plan
With DIGITS=4 unless noted:
- Encode `in_data`=16'h1234 → `out_data`=16'h4567, `out_err`=4'b0000. `out_valid` rises exactly 4 edges after accept.
- Decode 16'h4567 → 16'h1234, `out_err`=4'b0000.
- With `BCD_XS3_ERR_EN`, encode 16'h9A05 → `out_data`=16'hCD38, `out_err`=4'b0100, `out_any_err`=1.
- With `BCD_XS3_ERR_EN`, decode 16'h0000 → `out_data`=16'hDDDD, `out_err`=4'b1111.
- Backpressure: hold `out_ready` low for 5 cycles with `in_valid` high and a second word → `out_data` stable, `in_ready`=0, second word accepted only after the consume edge.
- Assert `rst` for 1 cycle during the second CONV cycle → `out_valid` never rises for that word, `in_ready`=1 the cycle after release, and the next word converts correctly. Repeat with DIGITS=1: encode 4'h7 → 4'hA with 1-cycle latency.

Source files
------------

// File: rtl/bcd_xs3_pkg.sv
// rtl/bcd_xs3_pkg.sv - shared types and constants for the BCD/XS3 serial codec
package bcd_xs3_pkg;

  typedef enum logic {
    ENCODE = 1'b0,
    DECODE = 1'b1
  } xs3_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } codec_state_t;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

endpackage

// File: rtl/bcd_xs3_serial_codec_xs3_digit.sv
// rtl/bcd_xs3_serial_codec_xs3_digit.sv - single-digit BCD<->XS3 converter; err output only with BCD_XS3_ERR_EN
module xs3_digit
  import bcd_xs3_pkg::*;
(
  input  logic [3:0] d,
  input  logic       mode,
`ifdef BCD_XS3_ERR_EN
  output logic       err,
`endif
  output logic [3:0] q
);

  // Wrapping 4-bit arithmetic: invalid codes still convert, never saturate.
  assign q = (xs3_mode_t'(mode) == DECODE) ? (d - XS3_OFFSET) : (d + XS3_OFFSET);

`ifdef BCD_XS3_ERR_EN
  assign err = (xs3_mode_t'(mode) == DECODE) ? ((d < XS3_MIN) || (d > XS3_MAX))
                                             : (d > BCD_MAX);
`endif

endmodule

// File: rtl/bcd_xs3_serial_codec.sv
// rtl/bcd_xs3_serial_codec.sv - nibble-serial BCD/XS3 word codec; per-digit error flags with BCD_XS3_ERR_EN
module bcd_xs3_serial_codec
  import bcd_xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
`ifdef BCD_XS3_ERR_EN
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_any_err,
`endif
  output logic                  busy
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  codec_state_t          state_q, state_d;
  logic [IDX_W-1:0]      idx_q;
  logic [4*DIGITS-1:0]   word_q;
  logic [4*DIGITS-1:0]   result_q;
  xs3_mode_t             mode_q;
  logic                  out_valid_q;
  logic [3:0]            digit_in;
  logic [3:0]            digit_out;
  logic                  accept;
  logic                  last_digit;

  assign in_ready   = (state_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign last_digit = (idx_q == LAST_IDX);
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_data   = result_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = CONV;
      CONV:    if (last_digit) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    digit_in = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) digit_in = word_q[4*i +: 4];
    end
  end

`ifdef BCD_XS3_ERR_EN
  logic                digit_err;
  logic [DIGITS-1:0]   err_q;
  logic [DIGITS-1:0]   err_next;
  logic                any_err_q;

  xs3_digit u_digit (
    .d    (digit_in),
    .mode (mode_q == DECODE),
    .err  (digit_err),
    .q    (digit_out)
  );

  always_comb begin
    err_next = err_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) err_next[i] = digit_err;
    end
  end

  // Stale high bits may leak into any_err mid-word; it is complete once out_valid rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= '0;
      any_err_q <= 1'b0;
    end else if (state_q == CONV) begin
      err_q     <= err_next;
      any_err_q <= |err_next;
    end
  end

  assign out_err     = err_q;
  assign out_any_err = any_err_q;
`else
  xs3_digit u_digit (
    .d    (digit_in),
    .mode (mode_q == DECODE),
    .q    (digit_out)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      word_q      <= '0;
      mode_q      <= ENCODE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            word_q <= in_data;
            mode_q <= xs3_mode_t'(in_mode);
            idx_q  <= '0;
          end
        end
        CONV: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) result_q[4*i +: 4] <= digit_out;
          end
          if (last_digit) out_valid_q <= 1'b1;
          else            idx_q       <= idx_q + IDX_W'(1);
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
